hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle.
// slave  : the hazard controller (consumes pipeline state, drives stall/flush controls)
// master : the pipeline side (drives pipeline state, consumes stall/flush controls)
interface hazard_ctrl_if;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RtAddress;
    logic        ID_EX_readSAD;
    logic [4:0]  IF_ID_RsAddress;
    logic [4:0]  IF_ID_RtAddress;
    logic        IF_ID_UsesRt;
    logic        branch_taken;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Bubble;
    logic        sad_busy;
    logic [15:0] stall_cycles;

    modport slave (
        input  ID_EX_MemRead, ID_EX_RtAddress, ID_EX_readSAD,
        input  IF_ID_RsAddress, IF_ID_RtAddress, IF_ID_UsesRt, branch_taken,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, sad_busy, stall_cycles
    );

    modport master (
        output ID_EX_MemRead, ID_EX_RtAddress, ID_EX_readSAD,
        output IF_ID_RsAddress, IF_ID_RtAddress, IF_ID_UsesRt, branch_taken,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, sad_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and a fixed
// stall window after a readSAD instruction leaves ID/EX.
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall_cycles
// counter; otherwise stall_cycles is tied to 0.
//
// state    | meaning
// RUN      | normal issue; load-use bubbles and branch flushes handled here
// SAD_WAIT | SAD result pending; front end frozen, bubbles fed into EX
module hazard_ctrl #(
    parameter int unsigned SAD_LATENCY = 3
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {RUN = 1'b0, SAD_WAIT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [3:0] sad_cnt, sad_cnt_nxt;
    logic       lu;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       busy;

    // Load-use detection: loaded register feeds the instruction behind it.
    always_comb begin
        lu = hz.ID_EX_MemRead && (hz.ID_EX_RtAddress != 5'd0) &&
             ((hz.ID_EX_RtAddress == hz.IF_ID_RsAddress) ||
              (hz.IF_ID_UsesRt && (hz.ID_EX_RtAddress == hz.IF_ID_RtAddress)));
    end

    // State and SAD window counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            sad_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            sad_cnt <= sad_cnt_nxt;
        end
    end

    // Next-state and pipeline control outputs; reset forces a frozen, flushed pipe.
    always_comb begin
        state_nxt    = state;
        sad_cnt_nxt  = sad_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                    if (hz.ID_EX_readSAD) begin
                        state_nxt   = SAD_WAIT;
                        sad_cnt_nxt = 4'(SAD_LATENCY - 1);
                    end
                end
                SAD_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    busy         = 1'b1;
                    if (sad_cnt == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        sad_cnt_nxt = sad_cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign hz.PCWrite      = pc_write;
    assign hz.IF_ID_Write  = if_id_write;
    assign hz.IF_ID_Flush  = if_id_flush;
    assign hz.ID_EX_Bubble = id_ex_bubble;
    assign hz.sad_busy     = busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of frozen-PC cycles since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
`else
    assign hz.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with SAD_LATENCY = 3.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.SAD_LATENCY(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, sad_busy}.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.sad_busy};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (pcw,ifw,flush,bubble,busy)", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        vectors++;
        assert (hz.stall_cycles === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, hz.stall_cycles, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic sad,
                         input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic br);
        hz.ID_EX_MemRead   = mr;
        hz.ID_EX_RtAddress = ex_rt;
        hz.ID_EX_readSAD   = sad;
        hz.IF_ID_RsAddress = rs;
        hz.IF_ID_RtAddress = rt;
        hz.IF_ID_UsesRt    = uses_rt;
        hz.branch_taken    = br;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    logic [15:0] exp_perf;

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef HAZARD_PERF_CNT_EN
        exp_perf = 16'd4;
`else
        exp_perf = 16'd0;
`endif
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_ctl("reset_outputs", 5'b00110);
        next_cycle();
        chk_cnt("reset_count", 16'd0);

        // Leave reset: idle RUN.
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0);
        chk_ctl("idle_run", 5'b11000);
        next_cycle();

        // lw rt=5 followed by rs=5 consumer: one bubble.
        drive(1'b1, 5'd5, 1'b0, 5'd5, 5'd9, 1'b0, 1'b0);
        chk_ctl("lu_rs_stall", 5'b00010);
        next_cycle();
        drive(1'b0, 5'd5, 1'b0, 5'd5, 5'd9, 1'b0, 1'b0);
        chk_ctl("lu_rs_release", 5'b11000);
        next_cycle();

        // r0 never hazards; rt match ignored when rt is not a source.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk_ctl("lu_r0_none", 5'b11000);
        next_cycle();
        drive(1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 1'b0, 1'b0);
        chk_ctl("lu_rt_unused", 5'b11000);
        next_cycle();

        // readSAD for one cycle: normal outputs now, then 3 stall cycles.
        drive(1'b0, 5'd0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
        chk_ctl("sad_issue", 5'b11000);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0);
        chk_ctl("sad_wait1", 5'b00011);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1);
        chk_ctl("sad_wait2_branch_ignored", 5'b00011);
        next_cycle();
        drive(1'b1, 5'd4, 1'b0, 5'd4, 5'd2, 1'b0, 1'b0);
        chk_ctl("sad_wait3_lu_ignored", 5'b00011);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0);
        chk_ctl("sad_back_to_run", 5'b11000);
        chk_cnt("perf_after_lu_and_sad", exp_perf);
        next_cycle();

        // rt match counts when rt is a source.
        drive(1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 1'b1, 1'b0);
        chk_ctl("lu_rt_used", 5'b00010);
        next_cycle();

        // Branch wins over load-use.
        drive(1'b1, 5'd6, 1'b0, 5'd6, 5'd0, 1'b0, 1'b1);
        chk_ctl("branch_over_lu", 5'b11110);
        next_cycle();

        // Branch together with readSAD: flush now, SAD window next.
        drive(1'b0, 5'd0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1);
        chk_ctl("branch_and_sad", 5'b11110);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0);
        chk_ctl("sad2_wait1", 5'b00011);
        next_cycle();

        // Reset on the 2nd SAD_WAIT cycle.
        rst = 1'b1;
        #1;
        chk_ctl("reset_mid_sad", 5'b00110);
        next_cycle();
        rst = 1'b0;
        #1;
        chk_ctl("after_reset_run", 5'b11000);
        chk_cnt("after_reset_count", 16'd0);
        next_cycle();
        chk_ctl("after_reset_still_run", 5'b11000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
